increment_scheduler: RTL and testbench
======================================

Name: increment_scheduler

Overview:
- Shares one combinational `incrementer` among N_CH independent event counters.
- Requesters pulse `req[i]`. The block queues one pending increment per channel and grants the shared incrementer to one channel per cycle, in round-robin order.
- Results are written back to per-channel count registers, with sticky overflow and drop flags.
- Sits between event sources (buttons, timers) and display/readout logic in the lab designs.

Parameters:
- WIDTH, 4, counter width in bits (passed to `incrementer`).
- N_CH, 4, number of channels/requesters (2..16).

Ports:
- clk  in  1  system clock, rising edge.
- reset_n  in  1  asynchronous active-low reset.
- req  in  N_CH  per-channel increment request; a 1-cycle pulse counts as one event.
- clear  in  N_CH  per-channel synchronous clear of count, ovf and pending.
- grant  out  N_CH  one-hot, combinational: channel served this cycle (all-zero if none).
- done  out  N_CH  registered one-cycle pulse: channel's count was updated at the previous edge.
- count  out  N_CH*WIDTH  packed count registers; channel i occupies bits [i*WIDTH +: WIDTH].
- ovf  out  N_CH  sticky: incrementer carry seen on that channel's update.
- drop  out  N_CH  sticky: a request was lost because the channel was already pending.

Behaviour:
- Interface: one clock, `clk`. Reset `reset_n` is asynchronous, active-low.
- Reset state:
  - count = 0, ovf = 0, drop = 0, pending = 0, done = 0.
  - Round-robin pointer = 0, so channel 0 has highest priority first.
- Pending:
  - `req[i]` sampled high at an edge sets pending[i].
  - pending[i] clears at the edge where channel i is served, unless `req[i]` is also high at that edge; then it stays set (new event queued).
- Drop: `req[i]` high while pending[i]=1 and channel i not served this cycle → request discarded, drop[i] <= 1.
- Arbitration:
  - Eligible set = pending & ~clear.
  - grant = first eligible channel searching ptr, ptr+1, … modulo N_CH.
  - When a grant occurs, ptr <= granted index + 1 (mod N_CH). With no grant, ptr holds.
- Datapath:
  - The granted channel's count drives the `incrementer` input.
  - At the edge: count[g] <= s; ovf[g] <= ovf[g] | c; done[g] <= 1.
  - All other done bits <= 0.
- Wrap-around: count 2^WIDTH-1 → 0, and ovf is set and stays set.
- Latency:
  - `req` at edge k → pending after edge k.
  - Earliest grant is in cycle k+1, count updated at edge k+1.
  - done pulse during cycle k+1..k+2.
  - Worst case N_CH cycles from pending to service.
- Clear:
  - `clear[i]` at an edge → count[i]=0, ovf[i]=0, drop[i]=0, pending[i]=0.
  - A `req[i]` in the same cycle is ignored (no drop).
  - Channel i is excluded from arbitration that cycle, so another eligible channel may be granted.
- Simultaneous requests from all channels → served in consecutive cycles, in pointer order; no starvation.
- Reset mid-operation: all state returns to reset values immediately. Pending requests are lost and do not set drop.
- The incrementer path is combinational, and count, ovf, done and drop are all registered.

Decomposition:
- Package `increment_scheduler_pkg`:
  - typedef `count_t` = logic[WIDTH-1:0] via parameterized-class or localparam default.
  - function `rr_next(ptr, N_CH)`.
- Sub-module `rr_arbiter`:
  - Parameter N_CH.
  - Inputs: eligible, ptr.
  - Outputs: one-hot grant, grant index, valid.
  - Purely combinational.
- Instantiate the existing `incrementer` (WIDTH) once. Do not duplicate adder logic in this block.

Test Plan (WIDTH=4, N_CH=4):
- Reset asserted mid-count (count[0]=5, pending=4'b0110) → all outputs 0 immediately; after release, first grant goes to ch0 when requested.
- Single req[2] pulse → grant=4'b0100 next cycle, then count[2]=1 and done=4'b0100 for exactly one cycle; ovf=0.
- req=4'b1111 for one cycle → grant sequence 0001, 0010, 0100, 1000 over four cycles; all counts =1; drop=0.
- 16 spaced pulses on req[1] → count[1] goes 15→0, ovf[1]=1; a 17th pulse leaves count[1]=1 and ovf[1] still 1.
- req[3] pulsed twice while ch0..ch2 are also pending with ptr=0 → second pulse sets drop[3]=1; count[3] ends at 1.
- clear[0] in the cycle ch0 would be granted, with pending=4'b0011 → ch1 granted instead; count[0]=0, pending[0]=0, no done[0].

Source files
------------

// File: rtl/increment_scheduler_pkg.sv
// increment_scheduler_pkg: shared types and helpers for the increment scheduler.
// Rev 1.0
`default_nettype none
package increment_scheduler_pkg;

  localparam int DEF_WIDTH = 4;
  localparam int PTR_W     = 4;  // holds any channel index up to 16 channels

  typedef logic [DEF_WIDTH-1:0] count_t;
  typedef logic [PTR_W-1:0]     ptr_t;

  function automatic ptr_t rr_next(input ptr_t ptr, input int n_ch);
    if (int'(ptr) >= n_ch - 1) return '0;
    return ptr + 1'b1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/increment_scheduler_rr_arbiter.sv
// rr_arbiter: combinational round-robin pick of the first eligible channel at or after ptr.
// Rev 1.0
`default_nettype none
module rr_arbiter
  import increment_scheduler_pkg::*;
#(
  parameter int N_CH = 4
) (
  input  logic [N_CH-1:0] eligible_i,
  input  ptr_t            ptr_i,
  output logic [N_CH-1:0] grant_o,
  output ptr_t            grant_idx_o,
  output logic            valid_o
);

  always_comb begin
    grant_o     = '0;
    grant_idx_o = '0;
    valid_o     = 1'b0;
    for (int k = 0; k < N_CH; k++) begin
      int j;
      j = int'(ptr_i) + k;
      if (j >= N_CH) j = j - N_CH;
      if (!valid_o && eligible_i[j]) begin
        valid_o     = 1'b1;
        grant_o[j]  = 1'b1;
        grant_idx_o = PTR_W'(j);
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/incrementer.sv
// incrementer: combinational WIDTH-bit +1 with carry out.
// Rev 1.0
`default_nettype none
module incrementer #(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0] a,
  output logic [WIDTH-1:0] s,
  output logic             c
);

  assign {c, s} = {1'b0, a} + {{WIDTH{1'b0}}, 1'b1};

endmodule
`default_nettype wire

// File: rtl/increment_scheduler.sv
// increment_scheduler: N_CH event counters sharing one incrementer under round-robin arbitration.
// Rev 1.0
`default_nettype none
module increment_scheduler
  import increment_scheduler_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int N_CH  = 4
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [N_CH-1:0]       req,
  input  logic [N_CH-1:0]       clear,
  output logic [N_CH-1:0]       grant,
  output logic [N_CH-1:0]       done,
  output logic [N_CH*WIDTH-1:0] count,
  output logic [N_CH-1:0]       ovf,
  output logic [N_CH-1:0]       drop
);

  logic [WIDTH-1:0] count_q [N_CH];
  logic [WIDTH-1:0] count_d [N_CH];
  logic [N_CH-1:0]  pending_q, pending_d;
  logic [N_CH-1:0]  ovf_q, ovf_d;
  logic [N_CH-1:0]  drop_q, drop_d;
  logic [N_CH-1:0]  done_q;
  ptr_t             ptr_q, ptr_d;

  logic [N_CH-1:0]  eligible;
  ptr_t             grant_idx;
  logic             grant_valid;
  logic [WIDTH-1:0] inc_a, inc_s;
  logic             inc_c;

  // A channel being cleared this cycle must not consume the incrementer.
  assign eligible = pending_q & ~clear;

  rr_arbiter #(.N_CH(N_CH)) u_arb (
    .eligible_i  (eligible),
    .ptr_i       (ptr_q),
    .grant_o     (grant),
    .grant_idx_o (grant_idx),
    .valid_o     (grant_valid)
  );

  always_comb begin
    inc_a = '0;
    for (int i = 0; i < N_CH; i++)
      if (grant[i]) inc_a = count_q[i];
  end

  incrementer #(.WIDTH(WIDTH)) u_inc (
    .a (inc_a),
    .s (inc_s),
    .c (inc_c)
  );

  always_comb begin
    count_d   = count_q;
    pending_d = pending_q;
    ovf_d     = ovf_q;
    drop_d    = drop_q;
    ptr_d     = grant_valid ? rr_next(grant_idx, N_CH) : ptr_q;
    for (int i = 0; i < N_CH; i++) begin
      if (clear[i]) begin
        count_d[i]   = '0;
        pending_d[i] = 1'b0;
        ovf_d[i]     = 1'b0;
        drop_d[i]    = 1'b0;
      end else begin
        pending_d[i] = req[i] | (pending_q[i] & ~grant[i]);
        drop_d[i]    = drop_q[i] | (req[i] & pending_q[i] & ~grant[i]);
        if (grant[i]) begin
          count_d[i] = inc_s;
          ovf_d[i]   = ovf_q[i] | inc_c;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < N_CH; i++) count_q[i] <= '0;
      pending_q <= '0;
      ovf_q     <= '0;
      drop_q    <= '0;
      done_q    <= '0;
      ptr_q     <= '0;
    end else begin
      count_q   <= count_d;
      pending_q <= pending_d;
      ovf_q     <= ovf_d;
      drop_q    <= drop_d;
      done_q    <= grant;
      ptr_q     <= ptr_d;
    end
  end

  for (genvar g = 0; g < N_CH; g++) begin : g_pack
    assign count[g*WIDTH +: WIDTH] = count_q[g];
  end

  assign done = done_q;
  assign ovf  = ovf_q;
  assign drop = drop_q;

endmodule
`default_nettype wire

// File: tb/tb_increment_scheduler.sv
// tb_increment_scheduler: directed self-checking bench for increment_scheduler (WIDTH=4, N_CH=4).
// Rev 1.0
`default_nettype none
module tb_increment_scheduler;

  localparam int WIDTH = 4;
  localparam int N_CH  = 4;

  logic                  clk = 1'b0;
  logic                  reset_n;
  logic [N_CH-1:0]       req;
  logic [N_CH-1:0]       clear;
  logic [N_CH-1:0]       grant;
  logic [N_CH-1:0]       done;
  logic [N_CH*WIDTH-1:0] count;
  logic [N_CH-1:0]       ovf;
  logic [N_CH-1:0]       drop;

  int n_checks = 0;
  int n_fail   = 0;

  increment_scheduler #(.WIDTH(WIDTH), .N_CH(N_CH)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .req     (req),
    .clear   (clear),
    .grant   (grant),
    .done    (done),
    .count   (count),
    .ovf     (ovf),
    .drop    (drop)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    req     = '0;
    clear   = '0;
    #3;
    reset_n = 1'b1;
    tick();
  endtask

  // One isolated event on channel ch: request edge, then the serving edge.
  task automatic pulse(input int ch);
    req     = '0;
    req[ch] = 1'b1;
    tick();
    req = '0;
    tick();
  endtask

  function automatic logic [WIDTH-1:0] cnt(input int ch);
    return count[ch*WIDTH +: WIDTH];
  endfunction

  initial begin
    req = '0; clear = '0; reset_n = 1'b0;
    #12;
    check("reset_count", 32'(count), 32'h0);
    check("reset_done",  32'(done),  32'h0);
    check("reset_ovf",   32'(ovf),   32'h0);
    check("reset_drop",  32'(drop),  32'h0);
    check("reset_grant", 32'(grant), 32'h0);
    @(negedge clk);
    reset_n = 1'b1;
    tick();

    // Reset mid-operation with count[0]=5 and pending=0110.
    for (int n = 0; n < 5; n++) pulse(0);
    check("pre_rst_cnt0", 32'(cnt(0)), 32'd5);
    req = 4'b0110;
    tick();
    req = '0;
    check("pre_rst_grant", 32'(grant), 32'b0010);
    #2 reset_n = 1'b0;
    #1;
    check("midrst_count", 32'(count), 32'h0);
    check("midrst_grant", 32'(grant), 32'h0);
    check("midrst_done",  32'(done),  32'h0);
    check("midrst_drop",  32'(drop),  32'h0);
    @(negedge clk);
    reset_n = 1'b1;
    req = 4'b0001;
    tick();
    req = '0;
    check("post_rst_grant", 32'(grant), 32'b0001);
    tick();
    check("post_rst_cnt0", 32'(cnt(0)), 32'd1);
    check("post_rst_done", 32'(done), 32'b0001);

    // Single req[2] pulse.
    do_reset();
    req = 4'b0100;
    tick();
    req = '0;
    check("single_grant", 32'(grant), 32'b0100);
    tick();
    check("single_cnt2", 32'(cnt(2)), 32'd1);
    check("single_done", 32'(done), 32'b0100);
    check("single_ovf",  32'(ovf), 32'h0);
    tick();
    check("single_done_off", 32'(done), 32'h0);

    // All channels at once: served in pointer order.
    do_reset();
    req = 4'b1111;
    tick();
    req = '0;
    check("all_g0", 32'(grant), 32'b0001);
    tick();
    check("all_g1", 32'(grant), 32'b0010);
    check("all_d0", 32'(done),  32'b0001);
    tick();
    check("all_g2", 32'(grant), 32'b0100);
    tick();
    check("all_g3", 32'(grant), 32'b1000);
    tick();
    check("all_idle", 32'(grant), 32'h0);
    check("all_count", 32'(count), 32'h1111);
    check("all_drop", 32'(drop), 32'h0);

    // Wrap-around on channel 1.
    do_reset();
    for (int n = 0; n < 15; n++) pulse(1);
    check("wrap_cnt15", 32'(cnt(1)), 32'd15);
    check("wrap_ovf_pre", 32'(ovf), 32'h0);
    pulse(1);
    check("wrap_cnt0", 32'(cnt(1)), 32'd0);
    check("wrap_ovf", 32'(ovf), 32'b0010);
    pulse(1);
    check("wrap_cnt1", 32'(cnt(1)), 32'd1);
    check("wrap_ovf_sticky", 32'(ovf), 32'b0010);

    // Second req[3] while still pending is dropped.
    do_reset();
    req = 4'b1111;
    tick();
    req = 4'b1000;
    check("drop_g0", 32'(grant), 32'b0001);
    tick();
    req = '0;
    check("drop_set", 32'(drop), 32'b1000);
    tick(); tick(); tick();
    check("drop_count", 32'(count), 32'h1111);
    check("drop_idle", 32'(grant), 32'h0);
    check("drop_sticky", 32'(drop), 32'b1000);

    // Clear on ch0 in its grant cycle hands the slot to ch1.
    do_reset();
    pulse(0);
    pulse(3);
    check("clr_pre_cnt0", 32'(cnt(0)), 32'd1);
    req = 4'b0011;
    tick();
    req = '0;
    clear = 4'b0001;
    #1;
    check("clr_grant", 32'(grant), 32'b0010);
    tick();
    clear = '0;
    check("clr_cnt0", 32'(cnt(0)), 32'd0);
    check("clr_cnt1", 32'(cnt(1)), 32'd1);
    check("clr_done", 32'(done), 32'b0010);
    check("clr_no_pend", 32'(grant), 32'h0);

    // Clear wins over a same-cycle request and resets drop.
    clear = 4'b1000;
    req   = 4'b1000;
    tick();
    clear = '0;
    req   = '0;
    check("clr_req_ignored", 32'(grant), 32'h0);
    check("clr_cnt3", 32'(cnt(3)), 32'd0);
    check("clr_drop", 32'(drop), 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
